// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC: one shared micro-rotation datapath stepped
// through ITER iterations by a three-state IDLE/RUN/DONE sequencer.
module cordic_iter_ctrl #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] z_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out,
    output logic        busy,
    output logic [4:0]  iter_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(ITER - 1);

    // atan(2^-i) rounded to the nearest unit of a 2^32 full circle
    localparam logic [31:0] ATAN_LUT [32] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    state_t             r_state;
    state_t             w_next_state;

    logic signed [31:0] r_x;
    logic signed [31:0] r_y;
    logic signed [31:0] r_z;
    logic [31:0]        r_x_out;
    logic [31:0]        r_y_out;
    logic [31:0]        r_z_out;
    logic [4:0]         r_iter;

    logic               w_in_fire;
    logic               w_last;
    logic               w_z_pos;
    logic signed [31:0] w_x_shr;
    logic signed [31:0] w_y_shr;
    logic signed [31:0] w_atan;
    logic signed [31:0] w_x_next;
    logic signed [31:0] w_y_next;
    logic signed [31:0] w_z_next;

    assign w_in_fire = in_valid && in_ready;
    assign w_last    = (r_state == S_RUN) && (r_iter == LAST_IDX);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values;
        // the x/y cross-update below depends on exactly that.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned
        // and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (r_iter == LAST_IDX) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_next_state = in_valid ? S_RUN : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // DONE accepts new operands only while the consumer takes the result
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_RUN:  busy     = 1'b1;
            S_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // z == 0 takes the negative-rotation branch
    assign w_z_pos  = (r_z > 32'sd0);
    assign w_x_shr  = r_x >>> r_iter;
    assign w_y_shr  = r_y >>> r_iter;
    assign w_atan   = $signed(ATAN_LUT[r_iter]);
    assign w_x_next = w_z_pos ? (r_x - w_y_shr) : (r_x + w_y_shr);
    assign w_y_next = w_z_pos ? (r_y + w_x_shr) : (r_y - w_x_shr);
    assign w_z_next = w_z_pos ? (r_z - w_atan)  : (r_z + w_atan);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
            r_iter  <= '0;
        end else if (w_in_fire) begin
            r_x    <= x_in;
            r_y    <= y_in;
            r_z    <= z_in;
            r_iter <= 5'd0;
        end else if (r_state == S_RUN) begin
            r_x <= w_x_next;
            r_y <= w_y_next;
            r_z <= w_z_next;
            if (w_last) begin
                r_x_out <= w_x_next;
                r_y_out <= w_y_next;
                r_z_out <= w_z_next;
                r_iter  <= 5'd0;
            end else begin
                r_iter <= r_iter + 5'd1;
            end
        end
    end

    assign x_out    = r_x_out;
    assign y_out    = r_y_out;
    assign z_out    = r_z_out;
    assign iter_idx = r_iter;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Scoreboard bench for cordic_iter_ctrl: a reference model computes each result
// at input handshake; a negedge monitor compares results, latency and iter_idx.
module tb_cordic_iter_ctrl;

    localparam int          ITER    = 16;
    localparam logic [31:0] K_SCALE = 32'h26DD_3B6A;
    localparam logic [31:0] TOL     = 32'h0001_0000;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic [31:0] z_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x_out;
    logic [31:0] y_out;
    logic [31:0] z_out;
    logic        busy;
    logic [4:0]  iter_idx;

    always #5 clk = ~clk;

    cordic_iter_ctrl #(.ITER(ITER)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .busy      (busy),
        .iter_idx  (iter_idx)
    );

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    logic [31:0] atan_ref [32];
    vec_t        exp_q [$];
    int          start_q [$];
    int          cyc     = 0;
    int          run_pos = -1;
    logic        prev_ov = 1'b0;
    logic        mon_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vectors++;
        if (obs !== exp_v) begin
            n_miscompares++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] within_tol(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] tol);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        if (d < 0) d = -d;
        return {31'b0, (d <= longint'(tol))};
    endfunction

    function automatic vec_t cordic_model(input logic [31:0] xi, input logic [31:0] yi,
                                          input logic [31:0] zi);
        logic signed [31:0] x, y, z, xs, ys;
        vec_t r;
        x = xi;
        y = yi;
        z = zi;
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (z > 0) begin
                x = x - ys;
                y = y + xs;
                z = z - $signed(atan_ref[i]);
            end else begin
                x = x + ys;
                y = y - xs;
                z = z + $signed(atan_ref[i]);
            end
        end
        r.x = x;
        r.y = y;
        r.z = z;
        return r;
    endfunction

    initial begin
        real a;
        for (int i = 0; i < 32; i++) begin
            a = $atan(1.0 / (2.0 ** i)) * 4294967296.0 / (2.0 * 3.14159265358979323846);
            atan_ref[i] = 32'($rtoi(a + 0.5));
        end
    end

    // Monitor: values seen at negedge are what the next posedge will sample
    always @(negedge clk) begin
        if (mon_en) begin
            vec_t e;
            cyc++;
            if (run_pos >= 0) begin
                check("busy_run", 32'(busy), 1);
                check("iter_idx", 32'(iter_idx), run_pos);
            end else begin
                check("busy_idle", 32'(busy), 0);
                check("iter_idle", 32'(iter_idx), 0);
            end
            if (out_valid && !prev_ov) begin
                if (start_q.size() == 0) check("unexp_out", 32'(start_q.size()), 1);
                else check("latency", cyc - start_q[0], ITER + 1);
            end
            prev_ov = out_valid;
            if (run_pos >= 0) begin
                run_pos++;
                if (run_pos == ITER) run_pos = -1;
            end
            if (rst) begin
                exp_q.delete();
                start_q.delete();
                run_pos = -1;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexp_hs", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        void'(start_q.pop_front());
                        check("sb_x", x_out, e.x);
                        check("sb_y", y_out, e.y);
                        check("sb_z", z_out, e.z);
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(cordic_model(x_in, y_in, z_in));
                    start_q.push_back(cyc);
                    run_pos = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        int k;
        x_in     = x;
        y_in     = y;
        z_in     = z;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        if (!out_valid) check("out_timeout", 32'(out_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        e;
        logic [31:0] rx;
        logic [31:0] ry;
        int          k;

        // Reset with a competing operand offer
        rst       = 1'b1;
        in_valid  = 1'b1;
        x_in      = 32'h1234_5678;
        y_in      = 32'h0BAD_F00D;
        z_in      = 32'h1000_0000;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_x_out", x_out, 0);
        check("rst_y_out", y_out, 0);
        check("rst_z_out", z_out, 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_iter_idx", 32'(iter_idx), 0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        tick();
        check("rst_no_capture", 32'(busy), 0);

        // Zero angle
        send(K_SCALE, 32'h0, 32'h0);
        wait_valid();
        check("zero_x_tol", within_tol(x_out, 32'h4000_0000, TOL), 1);
        check("zero_y_tol", within_tol(y_out, 32'h0, TOL), 1);
        check("zero_z_tol", within_tol(z_out, 32'h0, TOL), 1);
        tick();

        // +45 degrees
        send(K_SCALE, 32'h0, 32'h2000_0000);
        wait_valid();
        check("p45_x_tol", within_tol(x_out, 32'h2D41_3CCD, TOL), 1);
        check("p45_y_tol", within_tol(y_out, 32'h2D41_3CCD, TOL), 1);
        tick();

        // -90 degrees
        send(K_SCALE, 32'h0, 32'hC000_0000);
        wait_valid();
        check("m90_x_tol", within_tol(x_out, 32'h0, TOL), 1);
        check("m90_y_tol", within_tol(y_out, 32'hC000_0000, TOL), 1);
        tick();

        // Backpressure, then back-to-back accept on the releasing cycle
        out_ready = 1'b0;
        send(K_SCALE, 32'h0, 32'h1555_5555);
        e = cordic_model(K_SCALE, 32'h0, 32'h1555_5555);
        wait_valid();
        for (int h = 0; h < 5; h++) begin
            in_valid = 1'b1;
            x_in     = $urandom;
            y_in     = $urandom;
            z_in     = $urandom;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_x", x_out, e.x);
            check("hold_y", y_out, e.y);
            check("hold_z", z_out, e.z);
            tick();
        end
        out_ready = 1'b1;
        send(32'h1000_0000, 32'h0800_0000, 32'hE000_0000);
        wait_valid();
        tick();

        // Abort mid-run at iteration 7
        send(K_SCALE, 32'h0, 32'h3000_0000);
        k = 0;
        while (iter_idx != 5'd7 && k < 50) begin
            tick();
            k++;
        end
        check("abort_reach7", 32'(iter_idx), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_iter", 32'(iter_idx), 0);
        for (int w = 0; w < 20; w++) begin
            check("abort_no_valid", 32'(out_valid), 0);
            tick();
        end
        send(K_SCALE, 32'h0, 32'hEAAA_AAAB);
        wait_valid();
        tick();

        // Back-to-back random operands with out_ready held high
        for (int r = 0; r < 4; r++) begin
            rx = $urandom;
            ry = $urandom;
            send({{3{rx[28]}}, rx[28:0]}, {{3{ry[28]}}, ry[28:0]}, $urandom);
        end
        wait_valid();
        tick();

        repeat (3) tick();
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
Iterative CORDIC rotation-mode engine built around one shared micro-rotation datapath. A sequencer applies iteration i = 0..ITER-1 on successive cycles, using a shift of i and an internal arctan LUT entry. It replaces the unrolled chain of fixed-shift pipeline stages where area matters more than throughput. A valid/ready handshake is provided on both input and output.

Parameters:
ITER, 16, number of micro-rotations (legal 1..32); the shift amount and LUT index run 0..ITER-1.

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand offer
in_ready  output  1  block can accept operands this cycle
x_in  input  32  signed X, Q2.30
y_in  input  32  signed Y, Q2.30
z_in  input  32  signed angle; full circle = 2^32, so 0x40000000 = +90 deg
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
x_out  output  32  rotated X, Q2.30
y_out  output  32  rotated Y, Q2.30
z_out  output  32  residual angle
busy  output  1  high in RUN
iter_idx  output  5  current iteration index; 0 outside RUN

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- On rst: go to IDLE, clear the internal x/y/z registers, set x_out/y_out/z_out = 0, out_valid = 0, busy = 0, iter_idx = 0. in_ready follows the state equations below, so it is 1 in IDLE.
- Reset mid-operation: rst wins over every other event. The in-flight result is discarded and out_valid is not asserted.
- State IDLE:
  - in_ready = 1.
  - If in_valid, latch x_in/y_in/z_in, set iter_idx = 0, go to RUN.
- State RUN (in_ready = 0, busy = 1):
  - Each cycle performs one micro-rotation with i = iter_idx.
  - If $signed(z) > 0: x <= x - (y >>> i); y <= y + (x >>> i); z <= z - atan[i].
  - Else (this includes z == 0): x <= x + (y >>> i); y <= y - (x >>> i); z <= z + atan[i].
  - Shifts are arithmetic. Add/subtract is 32-bit two's complement with wrap-around; no saturation.
  - Both x and y updates use the pre-update values of x and y.
  - After the i = ITER-1 rotation: copy x/y/z to x_out/y_out/z_out, set out_valid = 1, go to DONE.
  - Otherwise increment iter_idx.
  - in_valid is ignored in RUN.
- State DONE:
  - out_valid = 1; outputs stay stable until handshake.
  - On out_ready: out_valid drops next cycle; go to IDLE.
  - in_ready = out_ready in DONE. If in_valid and out_ready occur in the same cycle, the new operands are latched and the state goes directly to RUN (back-to-back operation, no bubble).
- Latency:
  - Input handshake at cycle N gives out_valid = 1 at cycle N + ITER + 1.
  - With out_ready held high, throughput is one result per ITER + 1 cycles.
- LUT:
  - atan[i] = round(atan(2^-i) * 2^32 / (2*pi)), 32 entries, with only indices < ITER used.
  - First entries: 0x20000000, 0x12E4051E, 0x09FB385B, 0x051111D4, 0x028B0D43, 0x0145D7E1, 0x00A2F61E, 0x00517C55.
  - Entry 31 = 0x00000000 after rounding (it may be 0 or 1).
- Gain: no gain compensation is applied internally. The caller pre-scales X by K = 0.607252935 (0x26DD3B6A in Q2.30).
- in_valid asserted in the same cycle as rst is dropped.

Test Plan:
1. Reset check: rst for 2 cycles with in_valid = 1 -> all outputs 0, in_ready = 1, busy = 0, no capture.
2. Zero angle: x = 0x26DD3B6A, y = 0, z = 0, ITER = 16 -> out_valid exactly 17 cycles after the handshake; x_out within +/-0x10000 of 0x40000000, |y_out| <= 0x10000, |z_out| <= 0x00010000.
3. 45 deg: x = 0x26DD3B6A, y = 0, z = 0x20000000 -> x_out and y_out each within +/-0x10000 of 0x2D413CCD. Also check the golden bit-exact trace from the C model for iter_idx 0..15.
4. -90 deg: z = 0xC0000000, same x/y -> x_out near 0, y_out within +/-0x10000 of 0xC0000000. This exercises negative-z branches and arithmetic shift of negatives.
5. Backpressure and back-to-back:
   - Hold out_ready = 0 for 5 cycles after out_valid -> outputs stable, in_ready = 0, extra in_valid ignored.
   - Then out_ready = 1 with in_valid = 1 in the same cycle -> second operand is accepted and its result appears ITER + 1 cycles later.
6. Abort: assert rst at iter_idx = 7 -> next cycle IDLE, out_valid never pulses. A fresh operand afterwards produces a correct result.
